// File: rtl/l2_lookup_pipe_if.sv
// L2 lookup pipe handshake bundle: request, fill update and response.
// master drives req_*/upd_*/rsp_ready; slave (the pipe) drives the rest.
interface l2_lookup_pipe_if #(
   parameter int WAYS    = 8,
   parameter int WORDS   = 4,
   parameter int TAG_W   = 20,
   parameter int SETS    = 256,
   parameter int STATE_W = 3
);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int SET_W  = $clog2(SETS);

   logic                           req_valid;
   logic                           req_ready;
   logic                           req_mode;
   logic [SET_W-1:0]               req_set;
   logic [TAG_W-1:0]               req_tag;
   logic [WOFF_W-1:0]              req_w_off;
   logic [WAYS*TAG_W-1:0]          req_tags;
   logic [WAYS*WORDS*STATE_W-1:0]  req_states;

   logic                           upd_valid;
   logic [SET_W-1:0]               upd_set;
   logic [WAY_W-1:0]               upd_way;

   logic                           rsp_valid;
   logic                           rsp_ready;
   logic                           rsp_mode;
   logic                           rsp_tag_hit;
   logic                           rsp_empty_found;
   logic                           rsp_word_hit;
   logic                           rsp_multi_hit;
   logic [WAY_W-1:0]               rsp_way_hit;
   logic [WAY_W-1:0]               rsp_empty_way;
   logic [WAY_W-1:0]               rsp_evict_way;
   logic [STATE_W-1:0]             rsp_word_state;
   logic [WORDS-1:0]               rsp_mask_shared;
   logic [WORDS-1:0]               rsp_mask_owned;
   logic [WORDS-1:0]               rsp_mask_owned_evict;

   modport master (
      output req_valid, req_mode, req_set, req_tag, req_w_off,
      output req_tags, req_states,
      output upd_valid, upd_set, upd_way,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid, rsp_mode, rsp_tag_hit, rsp_empty_found,
      input  rsp_word_hit, rsp_multi_hit, rsp_way_hit, rsp_empty_way,
      input  rsp_evict_way, rsp_word_state, rsp_mask_shared,
      input  rsp_mask_owned, rsp_mask_owned_evict
   );

   modport slave (
      input  req_valid, req_mode, req_set, req_tag, req_w_off,
      input  req_tags, req_states,
      input  upd_valid, upd_set, upd_way,
      input  rsp_ready,
      output req_ready,
      output rsp_valid, rsp_mode, rsp_tag_hit, rsp_empty_found,
      output rsp_word_hit, rsp_multi_hit, rsp_way_hit, rsp_empty_way,
      output rsp_evict_way, rsp_word_state, rsp_mask_shared,
      output rsp_mask_owned, rsp_mask_owned_evict
   );
endinterface

// File: rtl/l2_lookup_pipe.sv
// L2 tag/state lookup with one registered valid/ready response stage,
// per-set round-robin eviction pointers and multi-hit detection.
// Ports: clk, rst (async, active-low), bus (l2_lookup_pipe_if.slave).
module l2_lookup_pipe #(
   parameter int WAYS    = 8,
   parameter int WORDS   = 4,
   parameter int TAG_W   = 20,
   parameter int SETS    = 256,
   parameter int STATE_W = 3
) (
   input logic             clk,
   input logic             rst,
   l2_lookup_pipe_if.slave bus
);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int WOFF_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [STATE_W-1:0] SPX_I = STATE_W'(0);
   localparam logic [STATE_W-1:0] SPX_S = STATE_W'(1);
   localparam logic [STATE_W-1:0] SPX_R = STATE_W'(2);
   localparam logic               L2_LOOKUP = 1'b0;

   typedef struct packed {
      logic               mode;
      logic               tag_hit;
      logic               empty_found;
      logic               word_hit;
      logic               multi_hit;
      logic [WAY_W-1:0]   way_hit;
      logic [WAY_W-1:0]   empty_way;
      logic [WAY_W-1:0]   evict_way;
      logic [STATE_W-1:0] word_state;
      logic [WORDS-1:0]   mask_shared;
      logic [WORDS-1:0]   mask_owned;
      logic [WORDS-1:0]   mask_owned_evict;
   } rsp_t;

   logic [STATE_W-1:0] st [WAYS][WORDS];
   logic [WAYS-1:0]    present;
   logic [WAYS-1:0]    match;
   logic [WAY_W-1:0]   hit_way;
   logic [WAY_W-1:0]   emp_way;
   logic [WAY_W-1:0]   evict_way;
   logic [STATE_W-1:0] sel_st;
   logic               lookup;
   logic               tag_hit;
   logic               any_empty;
   logic               accept;
   logic               rsp_valid_q;
   rsp_t               nxt;
   rsp_t               rsp_q;
   logic [WAY_W-1:0]   ptr [SETS];

   for (genvar i = 0; i < WAYS; i++) begin : g_way
      for (genvar j = 0; j < WORDS; j++) begin : g_word
         assign st[i][j] =
            bus.req_states[(i*WORDS+j)*STATE_W +: STATE_W];
      end
   end

   always_comb begin
      present = '0;
      match   = '0;
      for (int i = 0; i < WAYS; i++) begin
         for (int j = 0; j < WORDS; j++) begin
            if (st[i][j] > SPX_I) present[i] = 1'b1;
         end
         match[i] = present[i] &&
            (bus.req_tags[i*TAG_W +: TAG_W] == bus.req_tag);
      end
   end

   // Lowest index wins for both the hit way and the empty way.
   always_comb begin
      hit_way = '0;
      emp_way = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (match[i]) hit_way = WAY_W'(i);
         if (!present[i]) emp_way = WAY_W'(i);
      end
   end

   assign lookup    = (bus.req_mode == L2_LOOKUP);
   assign tag_hit   = |match;
   assign any_empty = |(~present);
   assign evict_way = ptr[bus.req_set];

   always_comb begin
      sel_st = '0;
      for (int j = 0; j < WORDS; j++) begin
         if (WOFF_W'(j) == bus.req_w_off) sel_st = st[hit_way][j];
      end
   end

   always_comb begin
      nxt             = '0;
      nxt.mode        = bus.req_mode;
      nxt.tag_hit     = tag_hit;
      nxt.way_hit     = hit_way;
      nxt.evict_way   = evict_way;
      // Two or more set bits: clearing the lowest leaves something.
      nxt.multi_hit   = (match & (match - WAYS'(1))) != '0;
      nxt.empty_found = lookup && any_empty;
      nxt.empty_way   = (lookup && any_empty) ? emp_way : '0;
      if (tag_hit && (sel_st > SPX_I)) begin
         nxt.word_hit   = 1'b1;
         nxt.word_state = sel_st;
      end
      for (int j = 0; j < WORDS; j++) begin
         if (tag_hit && st[hit_way][j] == SPX_R) begin
            nxt.mask_owned[j]  = 1'b1;
            nxt.mask_shared[j] = 1'b1;
         end
         if (tag_hit && st[hit_way][j] == SPX_S) begin
            nxt.mask_shared[j] = 1'b1;
         end
         if (lookup && !tag_hit && !any_empty &&
             st[evict_way][j] == SPX_R) begin
            nxt.mask_owned_evict[j] = 1'b1;
         end
      end
   end

   assign bus.req_ready = !rsp_valid_q || bus.rsp_ready;
   assign accept        = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= 1'b1;
         rsp_q       <= nxt;
      end else if (bus.rsp_ready) begin
         rsp_valid_q <= 1'b0;
      end
   end

   // Lookup reads ptr combinationally, so a same-edge update is
   // seen only by later lookups.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < SETS; s++) ptr[s] <= '0;
      end else if (bus.upd_valid) begin
         ptr[bus.upd_set] <= bus.upd_way + WAY_W'(1);
      end
   end

   assign bus.rsp_valid            = rsp_valid_q;
   assign bus.rsp_mode             = rsp_q.mode;
   assign bus.rsp_tag_hit          = rsp_q.tag_hit;
   assign bus.rsp_empty_found      = rsp_q.empty_found;
   assign bus.rsp_word_hit         = rsp_q.word_hit;
   assign bus.rsp_multi_hit        = rsp_q.multi_hit;
   assign bus.rsp_way_hit          = rsp_q.way_hit;
   assign bus.rsp_empty_way        = rsp_q.empty_way;
   assign bus.rsp_evict_way        = rsp_q.evict_way;
   assign bus.rsp_word_state       = rsp_q.word_state;
   assign bus.rsp_mask_shared      = rsp_q.mask_shared;
   assign bus.rsp_mask_owned       = rsp_q.mask_owned;
   assign bus.rsp_mask_owned_evict = rsp_q.mask_owned_evict;
endmodule

// File: tb/tb_l2_lookup_pipe.sv
// Bench for l2_lookup_pipe: table vectors, handshake/reset sequences
// and random traffic against a transaction-level reference model.
module tb_l2_lookup_pipe;
   localparam int WAYS = 4, WORDS = 4, SETS = 4, TAG_W = 8, STATE_W = 3;
   localparam int I = 0, S = 1, R = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   l2_lookup_pipe_if #(
      .WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W),
      .SETS(SETS), .STATE_W(STATE_W)
   ) bus ();

   l2_lookup_pipe #(
      .WAYS(WAYS), .WORDS(WORDS), .TAG_W(TAG_W),
      .SETS(SETS), .STATE_W(STATE_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic       mode;
      logic       tag_hit;
      logic       empty_found;
      logic       word_hit;
      logic       multi_hit;
      logic [1:0] way_hit;
      logic [1:0] empty_way;
      logic [1:0] evict_way;
      logic [2:0] word_state;
      logic [3:0] ms;
      logic [3:0] mo;
      logic [3:0] moe;
   } rsp_t;

   typedef struct {
      bit          mode;
      int          set;
      int          tag;
      int          woff;
      logic [31:0] tags;
      logic [47:0] st;
      rsp_t        exp;
   } vec_t;

   int   tests = 0;
   int   fails = 0;
   bit   m_valid = 0;
   rsp_t m_rsp = '0;
   int   ptr_m [SETS];
   vec_t tbl [8];

   localparam logic [31:0] T_ALL = 32'h04030201;
   localparam int          MISS  = 8'h77;

   function automatic logic [11:0] ln(int w0, int w1, int w2, int w3);
      return {3'(w3), 3'(w2), 3'(w1), 3'(w0)};
   endfunction

   function automatic int stv(logic [47:0] st, int i, int j);
      return int'(st[(i*4+j)*3 +: 3]);
   endfunction

   function automatic int tgv(logic [31:0] t, int i);
      return int'(t[i*8 +: 8]);
   endfunction

   function automatic rsp_t mk(bit md, bit th, bit ef, bit wh, bit mh,
                               int wy, int ew, int ev, int ws,
                               int ms, int mo, int moe);
      rsp_t r;
      r.mode = md; r.tag_hit = th; r.empty_found = ef;
      r.word_hit = wh; r.multi_hit = mh;
      r.way_hit = 2'(wy); r.empty_way = 2'(ew); r.evict_way = 2'(ev);
      r.word_state = 3'(ws);
      r.ms = 4'(ms); r.mo = 4'(mo); r.moe = 4'(moe);
      return r;
   endfunction

   function automatic rsp_t model(bit mode, int set, int tag, int woff,
                                  logic [31:0] tags, logic [47:0] st);
      rsp_t r;
      int nhit, hw, ew, nv, ev;
      r = '0; nhit = 0; hw = -1; ew = -1;
      ev = ptr_m[set];
      for (int i = 0; i < 4; i++) begin
         nv = 0;
         for (int j = 0; j < 4; j++) if (stv(st, i, j) > I) nv++;
         if (nv > 0 && tgv(tags, i) == tag) begin
            nhit++;
            if (hw < 0) hw = i;
         end
         if (nv == 0 && ew < 0) ew = i;
      end
      r.mode = mode;
      r.evict_way = 2'(ev);
      if (nhit > 0) begin
         r.tag_hit = 1;
         r.way_hit = 2'(hw);
         r.multi_hit = nhit >= 2;
         for (int j = 0; j < 4; j++) begin
            if (stv(st, hw, j) == R) begin r.mo[j] = 1; r.ms[j] = 1; end
            if (stv(st, hw, j) == S) r.ms[j] = 1;
         end
         if (stv(st, hw, woff) > I) begin
            r.word_hit = 1;
            r.word_state = 3'(stv(st, hw, woff));
         end
      end
      if (mode == 0 && ew >= 0) begin
         r.empty_found = 1;
         r.empty_way = 2'(ew);
      end
      if (mode == 0 && nhit == 0 && ew < 0)
         for (int j = 0; j < 4; j++)
            if (stv(st, ev, j) == R) r.moe[j] = 1;
      return r;
   endfunction

   function automatic rsp_t act();
      rsp_t r;
      r.mode = bus.rsp_mode; r.tag_hit = bus.rsp_tag_hit;
      r.empty_found = bus.rsp_empty_found; r.word_hit = bus.rsp_word_hit;
      r.multi_hit = bus.rsp_multi_hit; r.way_hit = bus.rsp_way_hit;
      r.empty_way = bus.rsp_empty_way; r.evict_way = bus.rsp_evict_way;
      r.word_state = bus.rsp_word_state; r.ms = bus.rsp_mask_shared;
      r.mo = bus.rsp_mask_owned; r.moe = bus.rsp_mask_owned_evict;
      return r;
   endfunction

   task automatic chk(string nm, longint got, longint exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Starts and ends at posedge+1.
   task automatic cycle(string nm, bit v, bit rr, bit mode, int set,
                        int tag, int woff, logic [31:0] tags,
                        logic [47:0] st, bit uv, int us, int uw);
      bit   acc;
      rsp_t nr;
      bus.req_valid = v;  bus.rsp_ready = rr;  bus.req_mode = mode;
      bus.req_set = 2'(set); bus.req_tag = 8'(tag);
      bus.req_w_off = 2'(woff); bus.req_tags = tags;
      bus.req_states = st; bus.upd_valid = uv;
      bus.upd_set = 2'(us); bus.upd_way = 2'(uw);
      #1;
      chk({nm, " req_ready"}, bus.req_ready, !m_valid || rr);
      acc = v && (!m_valid || rr);
      nr = model(mode, set, tag, woff, tags, st);
      @(posedge clk);
      if (acc) begin
         m_valid = 1;
         m_rsp = nr;
      end else if (rr) begin
         m_valid = 0;
      end
      if (uv) ptr_m[us] = (uw + 1) % WAYS;
      #1;
      chk({nm, " rsp_valid"}, bus.rsp_valid, m_valid);
      if (m_valid) chk({nm, " rsp"}, act(), m_rsp);
   endtask

   task automatic idle(string nm, bit uv, int us, int uw);
      cycle(nm, 0, 1, 0, 0, 0, 0, '0, '0, uv, us, uw);
   endtask

   task automatic apply(string nm, vec_t v, bit rr,
                        bit uv, int us, int uw);
      cycle(nm, 1, rr, v.mode, v.set, v.tag, v.woff, v.tags, v.st,
            uv, us, uw);
   endtask

   task automatic rnd_test(int n);
      logic [31:0] tags;
      logic [47:0] st;
      bit v, rr, md, uv;
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < 4; i++) begin
            tags[i*8 +: 8] = 8'(16 * (1 + $urandom_range(0, 3)));
            for (int j = 0; j < 4; j++)
               st[(i*4+j)*3 +: 3] = ($urandom_range(0, 3) == 0) ? 3'd0
                                    : 3'($urandom_range(0, 2));
         end
         v  = $urandom_range(0, 3) != 0;
         rr = $urandom_range(0, 3) != 0;
         md = $urandom_range(0, 3) == 0;
         uv = $urandom_range(0, 2) == 0;
         cycle("rnd", v, rr, md, $urandom_range(0, 3),
               16 * (1 + $urandom_range(0, 3)), $urandom_range(0, 3),
               tags, st, uv, $urandom_range(0, 3), $urandom_range(0, 3));
      end
   endtask

   initial begin
      rsp_t snap;
      logic [47:0] st_s;
      st_s = {ln(S,S,S,S), ln(S,S,S,S), ln(S,S,S,S), ln(S,S,S,S)};
      for (int s = 0; s < SETS; s++) ptr_m[s] = 0;

      tbl[0] = '{0, 0, 8'h5A, 1, 32'h035A0201,
         {ln(S,S,S,S), ln(R,S,I,I), ln(S,S,S,S), ln(S,S,S,S)},
         mk(0,1,0,1,0, 2,0,0, S, 4'b0011, 4'b0001, 0)};
      tbl[1] = '{0, 1, MISS, 0, T_ALL,
         {ln(S,S,S,S), ln(S,S,S,S), ln(S,S,S,S), ln(R,I,R,S)},
         mk(0,0,0,0,0, 0,0,0, 0, 0, 0, 4'b0101)};
      tbl[2] = '{0, 0, MISS, 0, T_ALL,
         {ln(I,I,I,I), ln(S,S,S,S), ln(I,I,I,I), ln(S,S,S,S)},
         mk(0,0,1,0,0, 0,1,0, 0, 0, 0, 0)};
      tbl[3] = '{1, 0, MISS, 0, T_ALL,
         {ln(I,I,I,I), ln(S,S,S,S), ln(I,I,I,I), ln(S,S,S,S)},
         mk(1,0,0,0,0, 0,0,0, 0, 0, 0, 0)};
      tbl[4] = '{0, 0, 8'h11, 2, 32'h22112211, st_s,
         mk(0,1,0,1,1, 0,0,0, S, 4'b1111, 0, 0)};
      tbl[5] = '{0, 0, 8'h33, 1, 32'h04033301,
         {ln(S,S,S,S), ln(S,S,S,S), ln(S,I,I,R), ln(S,S,S,S)},
         mk(0,1,0,0,0, 1,0,0, 0, 4'b1001, 4'b1000, 0)};
      tbl[6] = '{0, 0, 8'h44, 0, 32'h04030244,
         {ln(S,S,S,S), ln(S,S,S,S), ln(S,S,S,S), ln(I,I,I,I)},
         mk(0,0,1,0,0, 0,0,0, 0, 0, 0, 0)};
      tbl[7] = '{1, 3, 8'h5A, 3, 32'h035A0201,
         {ln(S,S,S,S), ln(R,R,I,S), ln(S,S,S,S), ln(S,S,S,S)},
         mk(1,1,0,1,0, 2,0,0, S, 4'b1011, 4'b0011, 0)};

      bus.req_valid = 0; bus.rsp_ready = 0; bus.req_mode = 0;
      bus.req_set = 0; bus.req_tag = 0; bus.req_w_off = 0;
      bus.req_tags = 0; bus.req_states = 0;
      bus.upd_valid = 0; bus.upd_set = 0; bus.upd_way = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset rsp_valid", bus.rsp_valid, 0);
      chk("reset fields", act(), 0);
      chk("reset req_ready", bus.req_ready, 1);
      rst = 1'b1;

      for (int k = 0; k < 8; k++) begin
         apply($sformatf("tbl%0d", k), tbl[k], 1, 0, 0, 0);
         chk($sformatf("tbl%0d exp", k), act(), tbl[k].exp);
      end

      idle("wrap upd", 1, 1, 3);
      apply("wrap look", tbl[1], 1, 0, 0, 0);
      chk("wrap evict_way", bus.rsp_evict_way, 0);
      chk("wrap moe", bus.rsp_mask_owned_evict, 4'b0101);
      idle("rr upd", 1, 1, 1);
      apply("rr look", tbl[1], 1, 0, 0, 0);
      chk("rr evict_way", bus.rsp_evict_way, 2);

      idle("bp drain", 0, 0, 0);
      apply("bp first", tbl[0], 0, 0, 0, 0);
      snap = act();
      for (int k = 0; k < 3; k++) begin
         apply("bp hold", tbl[4], 0, 0, 0, 0);
         chk("bp stable", act(), snap);
         chk("bp req_ready", bus.req_ready, 0);
      end
      apply("bp release", tbl[4], 1, 0, 0, 0);
      chk("bp second", act(), tbl[4].exp);

      cycle("same upd", 1, 1, 0, 2, MISS, 0, T_ALL, st_s, 1, 2, 1);
      chk("same old ptr", bus.rsp_evict_way, 0);
      cycle("same next", 1, 1, 0, 2, MISS, 0, T_ALL, st_s, 0, 0, 0);
      chk("same new ptr", bus.rsp_evict_way, 2);

      for (int s = 0; s < SETS; s++) idle("pre rst upd", 1, s, 1);
      apply("rst bp0", tbl[0], 0, 0, 0, 0);
      apply("rst bp1", tbl[4], 0, 0, 0, 0);
      rst = 1'b0;
      #2;
      chk("async rsp_valid", bus.rsp_valid, 0);
      chk("async fields", act(), 0);
      chk("async req_ready", bus.req_ready, 1);
      m_valid = 0;
      for (int s = 0; s < SETS; s++) ptr_m[s] = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      for (int s = 0; s < SETS; s++) begin
         cycle("post rst", 1, 1, 0, s, MISS, 0, T_ALL, tbl[1].st, 0, 0, 0);
         chk($sformatf("post rst ptr%0d", s), bus.rsp_evict_way, 0);
      end

      rnd_test(600);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/l2_lookup_pipe.md
# l2_lookup_pipe

Parametrised, handshaked successor of the L2 tag/state lookup. Given a set's tags and per-word states plus a request tag and word offset, it computes hit/miss, empty way, word-level hit state, shared/owned masks and the eviction-candidate owned mask. It sits between the L2 tag/state RAM read stage and the L2 request/forward FSMs. It adds three things: a registered valid/ready response stage, per-set round-robin eviction pointers, and multi-hit detection.

## Interface
Parameters:
- WAYS, 8: associativity; power of two, ≥2. WAY_W = $clog2(WAYS).
- WORDS, 4: words per line; power of two, ≥1. WOFF_W = max(1, $clog2(WORDS)).
- TAG_W, 20: tag width.
- SETS, 256: number of sets; power of two. SET_W = $clog2(SETS).
- STATE_W, 3: state width. Encodings are `SPX_I/`SPX_S/`SPX_R; "valid" means state > `SPX_I.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  lookup request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_mode  in  1  0 = `L2_LOOKUP (CPU request), 1 = `L2_LOOKUP_FWD (forward).
- req_set  in  SET_W  set index.
- req_tag  in  TAG_W  request tag.
- req_w_off  in  WOFF_W  requested word.
- req_tags  in  WAYS*TAG_W  tag of way i at [i*TAG_W +: TAG_W].
- req_states  in  WAYS*WORDS*STATE_W  state of way i, word j at [(i*WORDS+j)*STATE_W +: STATE_W].
- upd_valid  in  1  fill committed; advance the set's eviction pointer.
- upd_set  in  SET_W  set of the fill.
- upd_way  in  WAY_W  way filled.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_mode  out  1  echoed req_mode.
- rsp_tag_hit, rsp_empty_found, rsp_word_hit, rsp_multi_hit  out  1 each.
- rsp_way_hit, rsp_empty_way, rsp_evict_way  out  WAY_W each.
- rsp_word_state  out  STATE_W  state of the hit word.
- rsp_mask_shared, rsp_mask_owned, rsp_mask_owned_evict  out  WORDS each.

## Operation
- Line present in way i: any word state > `SPX_I.
- Tag hit: tag matches and line present. With several matches, the lowest index wins, and rsp_multi_hit = 1 when two or more ways hit.
- Empty way (`L2_LOOKUP only): lowest-index way with no valid word. Forced to 0/0 in `L2_LOOKUP_FWD.
- Word hit: tag_hit and states[way_hit][req_w_off] > `SPX_I. rsp_word_state carries that state; otherwise 0.
- Masks on tag hit: bit j of rsp_mask_owned and rsp_mask_shared is set if the word is `SPX_R; only rsp_mask_shared bit j is set if the word is `SPX_S. Both masks are 0 on a miss.
- Eviction: rsp_evict_way = ptr[req_set] in both modes. rsp_mask_owned_evict bit j = states[evict_way][j] == `SPX_R, only when mode = `L2_LOOKUP, no tag hit and no empty way; otherwise 0.
- Pointer update: on upd_valid, ptr[upd_set] <= (upd_way + 1) mod WAYS, wrapping WAYS-1 → 0.
- Fields that do not apply are 0, never X.

## Timing
- Latency: 1 cycle. An accept at edge N gives rsp_valid = 1 after edge N with all fields registered.
- req_ready = !rsp_valid || rsp_ready, so back-to-back accepts run at full throughput.
- Backpressure: while rsp_valid && !rsp_ready, all rsp_* fields hold stable and no request is accepted.
- rsp_valid drops after a consuming edge unless a new request is accepted on that same edge.
- Simultaneous update and accepted lookup on the same set: the lookup uses the pre-update pointer, and the update takes effect at that edge.
- Updates are accepted every cycle regardless of handshake state.
- Reset (async assert, any time, including mid-backpressure):
  - rsp_valid = 0 and all rsp_* fields = 0.
  - All pointers = 0.
  - req_ready = 1 from the first cycle after deassertion.
  - An in-flight response is discarded.

## Test plan
Bench configuration: WAYS=4, WORDS=4, SETS=4, TAG_W=8.
1. Hit. Way 2: tag 0x5A, states {R,S,I,I}; req_w_off=1, mode `L2_LOOKUP → next cycle:
   - rsp_tag_hit=1, way_hit=2, word_hit=1, word_state=`SPX_S
   - mask_owned=4'b0001, mask_shared=4'b0011, mask_owned_evict=0
2. Miss with eviction. All ways valid, no tag match, ptr[1]=0, way 0 states {R,I,R,S}:
   - tag_hit=0, empty_found=0, evict_way=0, mask_owned_evict=4'b0101
   - Then upd_set=1, upd_way=3 → a later lookup of set 1 shows evict_way=0 (wrap from 3).
3. Empty-way priority. Ways 1 and 3 fully `SPX_I, miss → empty_found=1, empty_way=1, mask_owned_evict=0. The same input in `L2_LOOKUP_FWD gives empty_found=0.
4. Multi-hit. Ways 0 and 2 both valid with tag 0x11 → tag_hit=1, way_hit=0, multi_hit=1.
5. Backpressure. Two back-to-back requests with rsp_ready=0 for 3 cycles:
   - The first response is held stable and req_ready=0.
   - After rsp_ready=1, the second response follows on the next cycle.
   - Same-cycle upd/lookup on set 2 returns the old pointer.
6. Reset. Assert rst mid-backpressure → rsp_valid=0 and all fields 0 immediately; after deassertion all pointers read 0.
